sample_window_buffer: RTL and testbench

- Parametrised circular sample-history buffer. It accepts a stream of DATA_W-bit audio samples through a valid/ready write port into an internal single-port synchronous RAM of depth 2^ADDR_W.
- On request, it returns a packed word of PACK consecutive historical samples: a tap window for the downstream FIR/effects path.
- Successor to the fixed 24-in/72-out block memory. It adds parametrised width, depth and pack factor, wrap-around history, fill tracking, offset-addressed reads, an error response and synchronous clear.

---
 rtl/sample_window_buffer.sv | 157 +++++++++++++++
 tb/tb_sample_window_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_window_buffer.sv
// Circular sample-history buffer with packed tap-window readout.
// Samples stream in through a valid/ready port into a single-port RAM.
// A read request returns PACK consecutive historical samples, newest first
// in the LSBs, or an error pulse if the requested window exceeds the history.
//
// state | meaning
// IDLE  | accepting samples, waiting for a window request
// FETCH | RAM reads in flight, writes frozen, packing the window
module sample_window_buffer #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int PACK   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_offset,
  output logic                     rd_busy,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [PACK*DATA_W-1:0]   rd_data,
  output logic [ADDR_W:0]          fill
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(PACK + 1);
  localparam int PW    = PACK * DATA_W;
  localparam logic [ADDR_W:0]   FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] PACK_W = (ADDR_W+2)'(PACK);
  localparam logic [CNT_W-1:0]  CNT_LD = CNT_W'(PACK);

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_fill;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [PW-1:0]       r_pack;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_err_pend;
  logic                r_rd_valid;
  logic                r_rd_err;
  logic [PW-1:0]       r_rd_data;

  logic                w_we;
  logic                w_start;
  logic                w_legal;
  logic                w_done;
  logic [ADDR_W:0]     w_fill_nxt;
  logic [ADDR_W-1:0]   w_wr_ptr_nxt;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W+1:0]   w_need;
  logic [PW-1:0]       w_pack_nxt;

  assign s_ready  = (r_state == ST_IDLE);
  assign rd_busy  = (r_state == ST_FETCH);
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign rd_data  = r_rd_data;
  assign fill     = r_fill;

  // Write acceptance, post-write fill/pointer, legality and next state.
  // Legality uses the post-write fill so a same-edge sample is part of the window.
  always_comb begin
    w_state_nxt  = r_state;
    w_we         = s_valid & (r_state == ST_IDLE) & ~clr;
    w_fill_nxt   = (w_we && (r_fill != FULL)) ? r_fill + (ADDR_W+1)'(1) : r_fill;
    w_wr_ptr_nxt = w_we ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    w_base       = w_wr_ptr_nxt - ADDR_W'(1) - rd_offset;
    w_need       = {2'b00, rd_offset} + PACK_W;
    w_legal      = (w_need <= {1'b0, w_fill_nxt});
    w_start      = rd_req & ~clr & (r_state == ST_IDLE);
    w_done       = (r_state == ST_FETCH) && (r_cnt == '0);
    case (r_state)
      ST_IDLE:  if (w_start && w_legal) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (clr) w_state_nxt = ST_IDLE;
  end

  // Pack register shift: newest RAM word enters at the MSB end, so the
  // first-read sample (k=0) ends up in the LSBs after PACK shifts.
  always_comb begin
    w_pack_nxt = '0;
    w_pack_nxt[(PACK-1)*DATA_W +: DATA_W] = r_q;
    for (int i = 0; i < PACK-1; i++) begin
      w_pack_nxt[i*DATA_W +: DATA_W] = r_pack[(i+1)*DATA_W +: DATA_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pointers, fill, fetch sequencing and the read response.
  // The fetch counter loads PACK and runs down; terminal count ends the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_rd_addr  <= '0;
      r_cnt      <= '0;
      r_pack     <= '0;
      r_err_pend <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_fill     <= w_fill_nxt;
      r_rd_valid <= 1'b0;
      r_err_pend <= w_start & ~w_legal;
      if (r_err_pend) begin
        r_rd_valid <= 1'b1;
        r_rd_err   <= 1'b1;
        r_rd_data  <= '0;
      end
      if (w_start && w_legal) begin
        r_rd_addr <= w_base;
        r_cnt     <= CNT_LD;
      end
      if (r_state == ST_FETCH) begin
        r_rd_addr <= r_rd_addr - ADDR_W'(1);
        r_pack    <= w_pack_nxt;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        if (w_done) begin
          r_rd_valid <= 1'b1;
          r_rd_err   <= 1'b0;
          r_rd_data  <= w_pack_nxt;
        end
      end
    end
  end

  // Single-port sample RAM: writes only in IDLE, reads only in FETCH.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= s_data;
    if (r_state == ST_FETCH) r_q <= r_mem[r_rd_addr];
  end

endmodule

// File: tb/tb_sample_window_buffer.sv
// Directed bench for sample_window_buffer (DATA_W=24, DEPTH=16, PACK=3).
module tb_sample_window_buffer;

  localparam int DW = 24;
  localparam int AW = 4;
  localparam int PK = 3;
  localparam int PW = DW * PK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_offset = '0;
  logic          rd_busy;
  logic          rd_valid;
  logic          rd_err;
  logic [PW-1:0] rd_data;
  logic [AW:0]   fill;

  int n_vec  = 0;
  int n_miss = 0;

  sample_window_buffer #(.DATA_W(DW), .ADDR_W(AW), .PACK(PK)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_req(rd_req), .rd_offset(rd_offset),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_data(rd_data), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic write_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(first + i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Issue one request (optionally with a same-edge write) and check the response.
  task automatic read_win(input string tag, input int off, input logic wr,
                          input logic [DW-1:0] wd, input logic exp_err,
                          input logic [PW-1:0] exp_data);
    int lat;
    int exp_lat;
    bit seen;
    exp_lat   = exp_err ? 1 : 4;
    rd_req    = 1'b1;
    rd_offset = AW'(off);
    s_valid   = wr;
    s_data    = wd;
    tick();
    rd_req  = 1'b0;
    s_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick();
      if (rd_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk({tag, "_lat"},  PW'(lat), PW'(exp_lat));
    chk({tag, "_err"},  PW'(rd_err), PW'(exp_err));
    chk({tag, "_data"}, rd_data, exp_data);
    tick();
    chk({tag, "_pulse"}, PW'(rd_valid), PW'(0));
  endtask

  initial begin
    int low_cnt;
    int pulses;
    bit wrote;
    logic [PW-1:0] got;

    #12;
    chk("rst_ready", PW'(s_ready),  PW'(1));
    chk("rst_busy",  PW'(rd_busy),  PW'(0));
    chk("rst_valid", PW'(rd_valid), PW'(0));
    chk("rst_err",   PW'(rd_err),   PW'(0));
    chk("rst_data",  rd_data,       PW'(0));
    chk("rst_fill",  PW'(fill),     PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1/2: ten samples, windows at offsets 0, 7 and the first illegal offset 8
    write_seq(16, 10);
    chk("t1_fill", PW'(fill), PW'(10));
    read_win("t1_off0", 0, 1'b0, '0, 1'b0, 72'h000017_000018_000019);
    read_win("t2_off7", 7, 1'b0, '0, 1'b0, 72'h000010_000011_000012);
    read_win("t2_off8", 8, 1'b0, '0, 1'b1, 72'h0);

    // 3: wrap-around, fill saturates
    do_clr();
    write_seq(0, 20);
    chk("t3_fill", PW'(fill), PW'(16));
    read_win("t3_off13", 13, 1'b0, '0, 1'b0, 72'h000004_000005_000006);
    read_win("t3_off14", 14, 1'b0, '0, 1'b1, 72'h0);

    // 4: writes held off during fetch, busy request ignored
    do_clr();
    write_seq(16, 10);
    rd_req    = 1'b1;
    rd_offset = '0;
    tick();
    rd_req  = 1'b0;
    chk("t4_busy", PW'(rd_busy), PW'(1));
    s_valid = 1'b1;
    s_data  = 24'h000055;
    low_cnt = 0;
    pulses  = 0;
    wrote   = 1'b0;
    got     = '0;
    for (int i = 0; i < 10; i++) begin
      rd_req    = (i == 1);
      rd_offset = AW'(5);
      if (!s_ready) low_cnt++;
      else if (s_valid) wrote = 1'b1;
      if (rd_valid) begin
        pulses++;
        got = rd_data;
      end
      tick();
      if (wrote) s_valid = 1'b0;
    end
    rd_req = 1'b0;
    chk("t4_low",    PW'(low_cnt), PW'(4));
    chk("t4_pulses", PW'(pulses),  PW'(1));
    chk("t4_data",   got,          72'h000017_000018_000019);
    chk("t4_fill",   PW'(fill),    PW'(11));
    read_win("t4_rb", 0, 1'b0, '0, 1'b0, 72'h000018_000019_000055);

    // 5: write and request on the same edge
    do_clr();
    write_seq(16, 10);
    read_win("t5_sim", 0, 1'b1, 24'h0000AA, 1'b0, 72'h000018_000019_0000AA);
    chk("t5_fill", PW'(fill), PW'(11));

    // 6a: clear mid-fetch
    do_clr();
    write_seq(16, 10);
    rd_req    = 1'b1;
    rd_offset = '0;
    tick();
    rd_req = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_valid) pulses++;
      tick();
    end
    chk("t6_pulses", PW'(pulses),  PW'(0));
    chk("t6_fill",   PW'(fill),    PW'(0));
    chk("t6_busy",   PW'(rd_busy), PW'(0));
    read_win("t6_empty", 0, 1'b0, '0, 1'b1, 72'h0);

    // 6b: async reset mid-fetch
    write_seq(1, 3);
    read_win("t6_pre", 0, 1'b0, '0, 1'b0, 72'h000001_000002_000003);
    rd_req    = 1'b1;
    rd_offset = '0;
    tick();
    rd_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6r_ready", PW'(s_ready),  PW'(1));
    chk("t6r_busy",  PW'(rd_busy),  PW'(0));
    chk("t6r_valid", PW'(rd_valid), PW'(0));
    chk("t6r_err",   PW'(rd_err),   PW'(0));
    chk("t6r_data",  rd_data,       PW'(0));
    chk("t6r_fill",  PW'(fill),     PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_valid) pulses++;
    end
    chk("t6r_pulses", PW'(pulses), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
